// File: rtl/mdp_pkg.sv
// Shared opcode/funct encodings, FSM states and ALU operations for the multicycle MIPS-subset datapath.
// Pure declarations: no latency, no flow control.
package mdp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

  function automatic logic funct_valid(input logic [5:0] f);
    logic v;
    v = (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) || (f == FN_SLT);
    return v;
  endfunction

  function automatic alu_op_t funct_alu(input logic [5:0] f);
    alu_op_t op;
    case (f)
      FN_SUB:  op = SUB;
      FN_AND:  op = AND;
      FN_OR:   op = OR;
      FN_SLT:  op = SLT;
      default: op = ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdp_regfile.sv
// 2-read/1-write register file; r0 reads zero and drops writes. Combinational reads,
// write lands on the clock edge; no flow control.
module mdp_regfile
  import mdp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     i_ra_a,
  input  logic [AW-1:0]     i_ra_b,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_regs [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd_a = (i_ra_a == '0) ? '0 : r_regs[i_ra_a];
  assign o_rd_b = (i_ra_b == '0) ? '0 : r_regs[i_ra_b];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction plus ack waits.
// Instruction/data memories are req/ack; requests hold address and data stable until ack.
module multicycle_datapath
  import mdp_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              REG_COUNT = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  localparam int AW = $clog2(REG_COUNT);

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_pc, r_alu_out, r_result, r_mdr, r_dmem_addr, r_dmem_wdata;

  logic [5:0]        w_op, w_funct;
  logic [AW-1:0]     w_rs, w_rt, w_rd;
  logic [DATA_W-1:0] w_imm, w_rs_val, w_rt_val, w_alu_b, w_alu_res;
  logic [DATA_W-1:0] w_pc4, w_br_target, w_j_target, w_wb_data;
  logic              w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j;
  logic              w_rf_we, w_retire;
  logic [AW-1:0]     w_rf_wa;
  alu_op_t           w_alu_op;

  assign w_op    = r_ir[31:26];
  assign w_funct = r_ir[5:0];
  assign w_rs    = r_ir[21 +: AW];
  assign w_rt    = r_ir[16 +: AW];
  assign w_rd    = r_ir[11 +: AW];
  assign w_imm   = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};

  // Unknown opcodes and unknown R-type functs all fall through as NOP (EXEC -> WB, no write).
  assign w_is_r    = (w_op == OP_RTYPE) && funct_valid(w_funct);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_j    = (w_op == OP_J);

  assign w_pc4       = r_pc + DATA_W'(4);
  assign w_br_target = w_pc4 + (w_imm << 2);
  assign w_j_target  = {w_pc4[DATA_W-1:28], r_ir[25:0], 2'b00};

  mdp_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .i_ra_a (w_rs),
    .i_ra_b (w_rt),
    .o_rd_a (w_rs_val),
    .o_rd_b (w_rt_val),
    .i_we   (w_rf_we),
    .i_wa   (w_rf_wa),
    .i_wd   (w_wb_data)
  );

  always_comb begin
    w_alu_op = ADD;
    if (w_op == OP_RTYPE) w_alu_op = funct_alu(w_funct);
    else if (w_is_beq)    w_alu_op = SUB;
  end

  assign w_alu_b = ((w_op == OP_RTYPE) || w_is_beq) ? w_rt_val : w_imm;

  always_comb begin
    case (w_alu_op)
      ADD:     w_alu_res = w_rs_val + w_alu_b;
      SUB:     w_alu_res = w_rs_val - w_alu_b;
      AND:     w_alu_res = w_rs_val & w_alu_b;
      OR:      w_alu_res = w_rs_val | w_alu_b;
      SLT:     w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_rs_val) < $signed(w_alu_b))};
      default: w_alu_res = '0;
    endcase
  end

  assign w_rf_we   = (r_state == WB) && (w_is_r || w_is_addi || w_is_lw);
  assign w_rf_wa   = w_is_r ? w_rd : w_rt;
  assign w_wb_data = w_is_lw ? r_mdr : r_alu_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      FETCH:  if (imem_ack) w_state_nxt = DECODE;
      DECODE: w_state_nxt = (w_op == OP_HALT) ? HALT : EXEC;
      EXEC: begin
        if (w_is_lw || w_is_sw) begin
          w_state_nxt = MEM;
        end else if (w_is_beq || w_is_j) begin
          w_state_nxt = FETCH;
          w_retire    = 1'b1;
        end else begin
          w_state_nxt = WB;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          if (w_is_lw) begin
            w_state_nxt = WB;
          end else begin
            w_state_nxt = FETCH;
            w_retire    = 1'b1;
          end
        end
      end
      WB: begin
        w_state_nxt = FETCH;
        w_retire    = 1'b1;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // PC only moves when an instruction retires, so it names the instruction in flight throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir         <= '0;
      r_pc         <= RESET_PC;
      r_alu_out    <= '0;
      r_result     <= '0;
      r_mdr        <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      case (r_state)
        FETCH: if (imem_ack) r_ir <= imem_rdata;
        EXEC: begin
          r_alu_out <= w_alu_res;
          if (w_is_lw || w_is_sw) begin
            r_dmem_addr  <= w_alu_res;
            r_dmem_wdata <= w_rt_val;
          end
          if (w_is_beq) r_pc <= (w_rs_val == w_rt_val) ? w_br_target : w_pc4;
          if (w_is_j)   r_pc <= w_j_target;
        end
        MEM: begin
          if (dmem_ack) begin
            if (w_is_lw) r_mdr <= dmem_rdata;
            else         r_pc  <= w_pc4;
          end
        end
        WB: begin
          r_pc <= w_pc4;
          if (w_rf_we) r_result <= w_wb_data;
        end
        default: ;
      endcase
    end
  end

  // FETCH is also the reset state, so the fetch request is masked while reset is held.
  assign imem_req   = (r_state == FETCH) && !rst;
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == MEM);
  assign dmem_we    = (r_state == MEM) && w_is_sw;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign alu_out    = r_alu_out;
  assign result     = r_result;
  assign pc         = r_pc;
  assign retire     = w_retire;
  assign halted     = (r_state == HALT);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: wait-state memory responders plus an instruction-level ISA model.
module tb_multicycle_datapath;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req, imem_ack;
  logic [DW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [DW-1:0] alu_out, result, pc;
  logic          retire, halted;

  multicycle_datapath #(.DATA_W(DW), .REG_COUNT(32), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_out(alu_out), .result(result), .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [31:0] imem     [256];
  logic [31:0] dmem_arr [256];
  int          iwait = 0, dwait = 0;
  bit          dm_stall = 0;
  int          stale_req = 0;
  int          n_vec = 0, n_err = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc, m_result;

  initial begin : imem_responder
    int cnt;
    cnt = 0; imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (cnt >= iwait) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr[9:2]]; cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : dmem_responder
    int cnt, stale_seen;
    cnt = 0; stale_seen = 0; dmem_ack = 1'b0; dmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      dmem_ack = 1'b0;
      if (stale_req != stale_seen) begin
        stale_seen = stale_req; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      end else if (dmem_req && !dm_stall) begin
        if (cnt >= dwait) begin
          dmem_ack = 1'b1; cnt = 0;
          if (dmem_we) dmem_arr[dmem_addr[9:2]] = dmem_wdata;
          else         dmem_rdata = dmem_arr[dmem_addr[9:2]];
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed no finish, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] a);
    return {6'h02, a};
  endfunction

  function automatic void wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
    m_result = v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0; m_result = '0;
  endfunction

  // Executes the instruction at m_pc architecturally and reports its expected cost and memory traffic.
  task automatic model_step(output int cyc, output bit is_mem, output bit we, output logic [31:0] addr, output logic [31:0] wd);
    logic [31:0] ins, a, b, imm, nxt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    ins = imem[m_pc[9:2]];
    op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a = m_reg[rs]; b = m_reg[rt]; imm = {{16{ins[15]}}, ins[15:0]};
    nxt = m_pc + 32'd4; is_mem = 0; we = 0; addr = '0; wd = '0; cyc = 4;
    if (op == 6'h00 && fn == 6'h20)      wr(rd, a + b);
    else if (op == 6'h00 && fn == 6'h22) wr(rd, a - b);
    else if (op == 6'h00 && fn == 6'h24) wr(rd, a & b);
    else if (op == 6'h00 && fn == 6'h25) wr(rd, a | b);
    else if (op == 6'h00 && fn == 6'h2A) wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
    else if (op == 6'h08) wr(rt, a + imm);
    else if (op == 6'h23) begin
      addr = a + imm; is_mem = 1; wr(rt, m_dmem[addr[9:2]]); cyc = 5 + dwait;
    end else if (op == 6'h2B) begin
      addr = a + imm; is_mem = 1; we = 1; wd = b; m_dmem[addr[9:2]] = b; cyc = 4 + dwait;
    end else if (op == 6'h04) begin
      if (a == b) nxt = nxt + (imm << 2);
      cyc = 3;
    end else if (op == 6'h02) begin
      nxt = {nxt[31:28], ins[25:0], 2'b00}; cyc = 3;
    end
    cyc = cyc + iwait;
    m_pc = nxt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_alu_out", alu_out, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input string tag, output int cyc_obs);
    int          ecyc, dreq_n;
    bit          is_mem, we;
    logic [31:0] eaddr, ewd, old_pc;
    old_pc = m_pc;
    model_step(ecyc, is_mem, we, eaddr, ewd);
    cyc_obs = 0; dreq_n = 0;
    do begin
      @(negedge clk); cyc_obs++;
      if (dmem_req) begin
        dreq_n++;
        chk({tag, "_daddr"}, dmem_addr, eaddr);
        chk({tag, "_dwe"}, {31'd0, dmem_we}, {31'd0, we});
        if (we) chk({tag, "_dwdata"}, dmem_wdata, ewd);
      end
    end while (!retire && cyc_obs < 64);
    chk({tag, "_cycles"}, cyc_obs, ecyc);
    chk({tag, "_pc_ret"}, pc, old_pc);
    chk({tag, "_dreq_cycles"}, dreq_n, is_mem ? 1 + dwait : 0);
    @(posedge clk); #1;
    chk({tag, "_pc_next"}, pc, m_pc);
    chk({tag, "_result"}, result, m_result);
  endtask

  task automatic do_halt(input string tag);
    int          c;
    logic [31:0] hpc;
    hpc = m_pc; c = 0;
    do begin
      @(negedge clk); c++;
    end while (!halted && c < 64);
    chk({tag, "_cycles"}, c, 3 + iwait);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, "_pc"}, pc, hpc);
    end
    chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic load_random();
    int k, rs, rt, rd, i;
    for (int j = 0; j < 256; j++) begin
      imem[j] = 32'hFC00_0000; dmem_arr[j] = $urandom; m_dmem[j] = dmem_arr[j];
    end
    for (i = 0; i < 30; i++) begin
      k = $urandom_range(0, 9); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      case (k)
        0: imem[i] = enc_r(5'(rs), 5'(rt), 5'(rd), 6'h20);
        1: imem[i] = enc_r(5'(rs), 5'(rt), 5'(rd), 6'h22);
        2: imem[i] = enc_r(5'(rs), 5'(rt), 5'(rd), 6'h24);
        3: imem[i] = enc_r(5'(rs), 5'(rt), 5'(rd), 6'h25);
        4: imem[i] = enc_r(5'(rs), 5'(rt), 5'(rd), 6'h2A);
        5: imem[i] = enc_i(6'h08, 5'(rs), 5'(rt), 16'($urandom));
        6: imem[i] = enc_i(6'h23, 5'd0, 5'(rt), 16'(4 * $urandom_range(0, 15)));
        7: imem[i] = enc_i(6'h2B, 5'd0, 5'(rt), 16'(4 * $urandom_range(0, 15)));
        8: imem[i] = enc_i(6'h0F, 5'(rs), 5'(rt), 16'($urandom));
        default: imem[i] = enc_i(6'h04, 5'(rs % 4), 5'(rt % 4), 16'($urandom_range(0, 2)));
      endcase
    end
    for (int r = 1; r < 8; r++) imem[29 + r] = enc_r(5'(r), 5'd0, 5'(r), 6'h25);
  endtask

  initial begin : main
    int c, c1, c2, c3, steps;
    for (int j = 0; j < 256; j++) begin imem[j] = 32'hFC00_0000; dmem_arr[j] = '0; m_dmem[j] = '0; end
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    imem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    imem[5]  = enc_i(6'h08, 5'd0, 5'd9, 16'd99);
    imem[6]  = enc_i(6'h08, 5'd0, 5'd9, 16'd99);
    imem[7]  = enc_r(5'd1, 5'd2, 5'd5, 6'h2A);
    imem[8]  = enc_r(5'd2, 5'd1, 5'd6, 6'h22);
    imem[9]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
    imem[10] = enc_i(6'h23, 5'd0, 5'd7, 16'd8);
    imem[11] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    imem[12] = enc_j(26'h40);
    imem[64] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[65] = enc_r(5'd0, 5'd0, 5'd8, 6'h20);

    iwait = 0; dwait = 0;
    do_reset();
    step("addi1", c1); step("addi2", c2); step("add", c3);
    chk("add_value", result, 32'd2);
    chk("first3_total_cycles", c1 + c2 + c3, 32'd12);
    step("slt_lt", c);   chk("slt_lt_value", result, 32'd1);
    step("beq_taken", c); chk("beq_taken_target", pc, 32'h1C);
    step("slt_ge", c);   chk("slt_ge_value", result, 32'd0);
    step("sub", c);      chk("sub_value", result, 32'hFFFF_FFF8);
    dwait = 3;
    step("sw_wait", c);  chk("sw_mem_word", dmem_arr[2], 32'd2);
    step("lw_wait", c);  chk("lw_value", result, 32'd2); chk("lw_cycles", c, 32'd8);
    dwait = 0;
    step("beq_not", c);  chk("beq_not_target", pc, 32'h30);
    step("j", c);        chk("j_imem_addr", imem_addr, 32'h100);
    step("addi_r0", c);
    step("add_r0", c);   chk("r0_reads_zero", result, 32'd0);
    do_halt("halt");

    for (int p = 0; p < 3; p++) begin
      load_random();
      iwait = 0; dwait = 0;
      do_reset();
      steps = 0;
      while (imem[m_pc[9:2]][31:26] != 6'h3F && steps < 80) begin
        iwait = $urandom_range(0, 2); dwait = $urandom_range(0, 2);
        step("rnd", c);
        steps++;
      end
      chk("rnd_reached_halt", {26'd0, imem[m_pc[9:2]][31:26]}, 32'h3F);
      do_halt("rnd_halt");
    end

    for (int j = 0; j < 256; j++) begin imem[j] = 32'hFC00_0000; dmem_arr[j] = '0; m_dmem[j] = '0; end
    imem[0] = enc_i(6'h2B, 5'd0, 5'd0, 16'd12);
    imem[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    iwait = 0; dwait = 0; dm_stall = 1;
    do_reset();
    c = 0;
    do begin @(negedge clk); c++; end while (!dmem_req && c < 20);
    chk("stall_in_mem", {31'd0, dmem_req}, 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midmem_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("midmem_rst_pc", pc, 32'd0);
    chk("midmem_rst_imem_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    dm_stall = 0; iwait = 2; stale_req++;
    rst = 1'b0;
    model_reset();
    step("restart_sw", c);
    chk("restart_sw_mem", dmem_arr[3], 32'd0);
    iwait = 0;
    step("restart_addi", c);
    chk("restart_addi_value", result, 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
